// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the sequence loader.
//   BASE_LEN        default bits per encoded base
//   BASE_N..BASE_T  one-hot base codes ('N' is all zeros)
//   loader_state_t  loader FSM states (FILL, HOLD)
package seq_pkg;

  localparam int BASE_LEN = 4;

  localparam logic [BASE_LEN-1:0] BASE_N = 4'b0000;
  localparam logic [BASE_LEN-1:0] BASE_A = 4'b0001;
  localparam logic [BASE_LEN-1:0] BASE_C = 4'b0010;
  localparam logic [BASE_LEN-1:0] BASE_G = 4'b0100;
  localparam logic [BASE_LEN-1:0] BASE_T = 4'b1000;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_t;

endpackage

// File: rtl/base_encoder.sv
// base_encoder: combinational ASCII to base-code mapper.
//   ascii_i  8-bit ASCII character
//   code_o   BASE_LEN-bit code; A/C/G/T in either case map to their one-hot
//            code, every other character maps to 'N' (all zeros)
module base_encoder
  import seq_pkg::*;
(
  input  logic [7:0]          ascii_i,
  output logic [BASE_LEN-1:0] code_o
);

  always_comb begin
    code_o = BASE_N;
    unique case (ascii_i)
      8'h41, 8'h61: code_o = BASE_A;  // 'A' / 'a'
      8'h43, 8'h63: code_o = BASE_C;  // 'C' / 'c'
      8'h47, 8'h67: code_o = BASE_G;  // 'G' / 'g'
      8'h54, 8'h74: code_o = BASE_T;  // 'T' / 't'
      default:      code_o = BASE_N;
    endcase
  end

endmodule

// File: rtl/seq_loader.sv
// seq_loader: packs a valid/ready stream of bases into a flat memory image.
// Optional feature macro: SEQ_LOADER_ASCII_EN (8-bit ASCII input, mapped by
// base_encoder); otherwise in_base is a BASE_LEN-bit code written verbatim.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   in_valid/in_ready/in_base/in_last   input base stream
//   memory        packed image, slot k at [k*BASE_LEN +: BASE_LEN]
//   mem_valid     image complete and stable (HOLD state)
//   seq_len       number of bases written (0..ACTUAL_MEM)
//   truncated     capacity reached without in_last
//   release_mem   downstream done with the image (honoured in HOLD only)
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state, never on in_valid, so the
// source may hold a beat indefinitely while in_ready is low.
module seq_loader #(
  parameter int BASE_LEN   = seq_pkg::BASE_LEN,
  parameter int ACTUAL_MEM = 32,
  parameter int MEM_LEN    = ACTUAL_MEM * BASE_LEN,
  parameter int INDICE_LEN = $clog2(ACTUAL_MEM),
`ifdef SEQ_LOADER_ASCII_EN
  localparam int IN_W      = 8
`else
  localparam int IN_W      = BASE_LEN
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_base,
  input  logic                  in_last,
  output logic [MEM_LEN-1:0]    memory,
  output logic                  mem_valid,
  output logic [INDICE_LEN:0]   seq_len,
  output logic                  truncated,
  input  logic                  release_mem
);

  import seq_pkg::*;

  loader_state_t           state_q, state_d;
  logic [INDICE_LEN-1:0]   wr_ptr_q, wr_ptr_d;
  logic [INDICE_LEN:0]     seq_len_q, seq_len_d;
  logic                    truncated_q, truncated_d;
  logic [MEM_LEN-1:0]      memory_q, memory_d;
  logic [BASE_LEN-1:0]     enc_base;
  logic                    accept;
  logic                    last_slot;

`ifdef SEQ_LOADER_ASCII_EN
  base_encoder u_base_encoder (
    .ascii_i (in_base),
    .code_o  (enc_base)
  );
`else
  assign enc_base = in_base;
`endif

  assign accept    = (state_q == FILL) && in_valid;
  assign last_slot = (wr_ptr_q == INDICE_LEN'(ACTUAL_MEM - 1));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    seq_len_d   = seq_len_q;
    truncated_d = truncated_q;
    memory_d    = memory_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          memory_d[int'(wr_ptr_q) * BASE_LEN +: BASE_LEN] = enc_base;
          seq_len_d = seq_len_q + (INDICE_LEN + 1)'(1);
          // On the last slot the pointer is parked instead of wrapping;
          // HOLD is entered on this same beat.
          if (!last_slot) begin
            wr_ptr_d = wr_ptr_q + INDICE_LEN'(1);
          end
          if (in_last || last_slot) begin
            state_d     = HOLD;
            truncated_d = last_slot && !in_last;
          end
        end
      end
      HOLD: begin
        if (release_mem) begin
          state_d     = FILL;
          wr_ptr_d    = '0;
          seq_len_d   = '0;
          truncated_d = 1'b0;
          memory_d    = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      seq_len_q   <= '0;
      truncated_q <= 1'b0;
      memory_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      seq_len_q   <= seq_len_d;
      truncated_q <= truncated_d;
      memory_q    <= memory_d;
    end
  end

  // Both handshake outputs are pure decodes of the state register.
  assign in_ready  = (state_q == FILL);
  assign mem_valid = (state_q == HOLD);
  assign memory    = memory_q;
  assign seq_len   = seq_len_q;
  assign truncated = truncated_q;

endmodule

// File: tb/tb_seq_loader.sv
// tb_seq_loader: directed bench for seq_loader with an expected-image queue.
module tb_seq_loader;

  localparam int BASE_LEN   = 4;
  localparam int ACTUAL_MEM = 32;
  localparam int MEM_LEN    = ACTUAL_MEM * BASE_LEN;
  localparam int INDICE_LEN = 5;
`ifdef SEQ_LOADER_ASCII_EN
  localparam int IN_W = 8;
`else
  localparam int IN_W = BASE_LEN;
`endif
  // Scoreboard entry: {truncated, seq_len, memory}
  localparam int W = 1 + INDICE_LEN + 1 + MEM_LEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [IN_W-1:0]       in_base = '0;
  logic                  in_last = 1'b0;
  logic [MEM_LEN-1:0]    memory;
  logic                  mem_valid;
  logic [INDICE_LEN:0]   seq_len;
  logic                  truncated;
  logic                  release_mem = 1'b0;

  seq_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_base     (in_base),
    .in_last     (in_last),
    .memory      (memory),
    .mem_valid   (mem_valid),
    .seq_len     (seq_len),
    .truncated   (truncated),
    .release_mem (release_mem)
  );

  // ---------------- model + scoreboard ----------------
  logic [BASE_LEN-1:0] mdl_mem [ACTUAL_MEM];
  int                  mdl_len;
  logic                mdl_trunc;
  logic [W-1:0]        exp_q[$];
  logic [W-1:0]        last_img;
  int                  n_vec = 0;
  int                  n_err = 0;

  function automatic logic [W-1:0] mdl_img();
    logic [MEM_LEN-1:0] m;
    m = '0;
    for (int k = 0; k < ACTUAL_MEM; k++) m[k*BASE_LEN +: BASE_LEN] = mdl_mem[k];
    return {mdl_trunc, (INDICE_LEN + 1)'(mdl_len), m};
  endfunction

  function automatic logic [W-1:0] dut_img();
    return {truncated, seq_len, memory};
  endfunction

  task automatic mdl_clear();
    for (int k = 0; k < ACTUAL_MEM; k++) mdl_mem[k] = '0;
    mdl_len   = 0;
    mdl_trunc = 1'b0;
  endtask

`ifdef SEQ_LOADER_ASCII_EN
  function automatic logic [BASE_LEN-1:0] enc_ref(input logic [IN_W-1:0] c);
    if (c == "A" || c == "a") return 4'b0001;
    if (c == "C" || c == "c") return 4'b0010;
    if (c == "G" || c == "g") return 4'b0100;
    if (c == "T" || c == "t") return 4'b1000;
    return 4'b0000;
  endfunction
`else
  function automatic logic [BASE_LEN-1:0] enc_ref(input logic [IN_W-1:0] c);
    return c;
  endfunction
`endif

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one beat from a negedge; it transfers at the next posedge if
  // in_ready was high (in_ready only changes on posedges).
  task automatic beat(input logic [IN_W-1:0] code, input logic last);
    logic acc;
    @(negedge clk);
    in_valid = 1'b1;
    in_base  = code;
    in_last  = last;
    acc      = in_ready;
    @(posedge clk);
    if (acc && mdl_len < ACTUAL_MEM) begin
      mdl_mem[mdl_len] = enc_ref(code);
      mdl_len++;
      if (last || mdl_len == ACTUAL_MEM) begin
        mdl_trunc = !last;
        exp_q.push_back(mdl_img());
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Idle cycles with junk on the data lines.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_base  = IN_W'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_last = 1'b0;
  endtask

  // Called right after the final beat: HOLD must be visible one cycle later.
  task automatic check_hold(input string tag);
    @(negedge clk);
    chk({tag, "_mem_valid"}, W'(mem_valid), W'(1));
    chk({tag, "_in_ready"}, W'(in_ready), W'(0));
    if (exp_q.size() == 0) begin
      chk({tag, "_no_expect"}, W'(1), W'(0));
    end else begin
      last_img = exp_q.pop_front();
      chk({tag, "_image"}, dut_img(), last_img);
    end
  endtask

  task automatic do_release(input string tag);
    @(negedge clk);
    release_mem = 1'b1;
    @(posedge clk);
    #1;
    release_mem = 1'b0;
    in_valid    = 1'b0;
    mdl_clear();
    @(negedge clk);
    chk({tag, "_rel_image"}, dut_img(), W'(0));
    chk({tag, "_rel_mem_valid"}, W'(mem_valid), W'(0));
    chk({tag, "_rel_in_ready"}, W'(in_ready), W'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_image"}, dut_img(), W'(0));
    chk({tag, "_mem_valid"}, W'(mem_valid), W'(0));
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    mdl_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

`ifdef SEQ_LOADER_ASCII_EN
    // ASCII mapping, mixed case and an unknown character
    beat("a", 1'b0); beat("C", 1'b0); beat("g", 1'b0); beat("X", 1'b0); beat("T", 1'b1);
    check_hold("ascii");
    chk("ascii_slots", W'(memory), W'(20'h80421));
    chk("ascii_len", W'(seq_len), W'(5));
    do_release("ascii");
`else
    // Short sequence
    beat(4'h1, 1'b0); beat(4'h2, 1'b0); beat(4'h4, 1'b0); beat(4'h8, 1'b1);
    check_hold("short");
    chk("short_mem", W'(memory), W'(16'h8421));
    chk("short_len", W'(seq_len), W'(4));

    // HOLD ignores offered beats
    @(negedge clk);
    in_valid = 1'b1; in_base = 4'hf;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("hold_frozen", W'(memory), W'(16'h8421));
    chk("hold_in_ready", W'(in_ready), W'(0));
    // release while in_valid stays high: nothing is taken on the release edge
    do_release("short");

    beat(4'h3, 1'b0); beat(4'h5, 1'b1);
    check_hold("two");
    chk("two_mem", W'(memory), W'(8'h53));
    do_release("two");
`endif

    // Capacity without last
    for (int i = 0; i < ACTUAL_MEM; i++) beat(IN_W'($urandom_range(0, 255)), 1'b0);
    check_hold("cap");
    chk("cap_trunc", W'(truncated), W'(1));
    chk("cap_len", W'(seq_len), W'(32));
    @(negedge clk);
    in_valid = 1'b1; in_base = IN_W'(8'h41); in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("cap_33rd_ready", W'(in_ready), W'(0));
    end
    chk("cap_33rd_image", dut_img(), last_img);
    in_valid = 1'b0; in_last = 1'b0;
    do_release("cap");

    // Capacity with last on the final slot
    for (int i = 0; i < ACTUAL_MEM; i++) beat(IN_W'($urandom_range(0, 255)), i == ACTUAL_MEM - 1);
    check_hold("caplast");
    chk("caplast_trunc", W'(truncated), W'(0));
    chk("caplast_len", W'(seq_len), W'(32));
    do_release("caplast");

    // release_mem has no effect in FILL
    beat(IN_W'(8'h43), 1'b0);
    @(negedge clk);
    release_mem = 1'b1;
    @(posedge clk);
    #1 release_mem = 1'b0;
    @(negedge clk);
    chk("fill_rel_image", dut_img(), mdl_img());
    chk("fill_rel_ready", W'(in_ready), W'(1));
    beat(IN_W'(8'h47), 1'b1);
    check_hold("fill_rel");
    do_release("fill_rel");

    // Gappy load, then reset after beat 5
    for (int i = 0; i < 5; i++) begin
      idle($urandom_range(0, 2));
      beat(IN_W'($urandom_range(0, 255)), 1'b0);
    end
    idle(1);
    @(negedge clk);
    chk("gap_partial", dut_img(), mdl_img());
    in_valid = 1'b1; in_base = IN_W'(8'h54);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    mdl_clear();
    @(negedge clk);
    check_reset_vals("midreset");

    // Full gappy 10-base load
    for (int i = 0; i < 10; i++) begin
      idle($urandom_range(0, 3));
      beat(IN_W'($urandom_range(0, 255)), i == 9);
    end
    check_hold("gap10");
    chk("gap10_len", W'(seq_len), W'(10));

    // Reset while holding
    @(negedge clk);
    rst = 1'b1; release_mem = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    mdl_clear();
    @(negedge clk);
    check_reset_vals("holdreset");

    chk("queue_drained", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
